// File: rtl/imem_load_controller_if.sv
// Bus bundle between the instruction-memory load controller, the fetch stage,
// the byte-stream loader and the instruction memory.
interface imem_load_controller_if #(
  parameter int unsigned DATA_WIDTH    = 20,
  parameter int unsigned ADDRESS_WIDTH = 8
);

  // Loader control and byte stream
  logic                     load_start;
  logic [ADDRESS_WIDTH:0]   load_count;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;

  // Fetch stage and instruction memory
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;

  // Pipeline control and status
  logic                     cpu_stall;
  logic                     cpu_restart;
  logic                     load_done;
  logic                     load_err;
  logic [ADDRESS_WIDTH:0]   words_loaded;

  // Environment side: loader, fetch stage and memory
  modport master (
    output load_start, load_count, byte_valid, byte_data, fetch_addr,
    input  byte_ready, mem_addr, mem_wdata, mem_we, cpu_stall, cpu_restart,
           load_done, load_err, words_loaded
  );

  // Controller side
  modport slave (
    input  load_start, load_count, byte_valid, byte_data, fetch_addr,
    output byte_ready, mem_addr, mem_wdata, mem_we, cpu_stall, cpu_restart,
           load_done, load_err, words_loaded
  );

endinterface

// File: rtl/imem_load_controller.sv
// Instruction memory load controller: arbitrates the instruction memory between
// the fetch stage and a byte-stream loader, packing 3 bytes per word (MSB first),
// writing from address 0 upward, then restarting the pipeline.
// DATA_WIDTH must not exceed 24.
module imem_load_controller #(
  parameter int unsigned DATA_WIDTH    = 20,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned MEM_SIZE      = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_load_controller_if.slave bus
);

  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;
  localparam int unsigned ASM_W = 24;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [1:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_target;
  logic [ASM_W-1:0] r_asm;
  logic             r_load_err;

  logic             w_byte_fire;
  logic             w_over;
  logic             w_hi_err;
  logic [CNT_W-1:0] w_wptr_inc;
  logic [CNT_W-1:0] w_count_clamped;

  assign w_byte_fire     = bus.byte_valid && (r_state == S_RECV);
  assign w_wptr_inc      = r_wptr + CNT_W'(1);
  assign w_over          = bus.load_count > CNT_W'(MEM_SIZE);
  assign w_count_clamped = w_over ? CNT_W'(MEM_SIZE) : bus.load_count;

  // Flag assembled bits that do not fit in an instruction word
  generate
    if (DATA_WIDTH < ASM_W) begin : g_hi_chk
      assign w_hi_err = |r_asm[ASM_W-1:DATA_WIDTH];
    end else begin : g_no_hi_chk
      assign w_hi_err = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.load_start) begin
          w_state_next = (bus.load_count == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (w_byte_fire && (r_byte_cnt == 2'd2)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_next = (w_wptr_inc == r_target) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Load bookkeeping: target, write pointer, byte assembly and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_wptr     <= '0;
      r_target   <= '0;
      r_asm      <= '0;
      r_load_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load_start) begin
            r_wptr     <= '0;
            r_byte_cnt <= '0;
            r_target   <= w_count_clamped;
            r_load_err <= w_over;
          end
        end
        S_RECV: begin
          if (w_byte_fire) begin
            r_asm      <= {r_asm[ASM_W-9:0], bus.byte_data};
            r_byte_cnt <= (r_byte_cnt == 2'd2) ? 2'd0 : r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_wptr <= w_wptr_inc;
          if (w_hi_err) begin
            r_load_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the state register; memory address muxed by owner
  always_comb begin
    bus.byte_ready   = (r_state == S_RECV);
    bus.mem_we       = (r_state == S_WRITE);
    bus.cpu_stall    = (r_state != S_IDLE);
    bus.load_done    = (r_state == S_DONE);
    bus.cpu_restart  = (r_state == S_DONE);
    bus.mem_wdata    = r_asm[DATA_WIDTH-1:0];
    bus.load_err     = r_load_err;
    bus.words_loaded = r_wptr;
    bus.mem_addr     = (r_state == S_IDLE) ? bus.fetch_addr
                                           : r_wptr[ADDRESS_WIDTH-1:0];
  end

endmodule

// File: tb/tb_imem_load_controller.sv
// Scoreboard bench for imem_load_controller: stimulus pushes expected memory
// writes and load completions; a negedge monitor pops and compares them.
module tb_imem_load_controller;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 20;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [AW:0] words;
    logic        err;
  } done_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  wr_t        wq[$];
  done_t      dq[$];
  logic [7:0] tx[$];
  logic [DW-1:0] mem_model [256];

  always #5 clk = ~clk;

  imem_load_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  imem_load_controller #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory model
  always @(posedge clk) if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every write and every completion against the scoreboard
  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (rst_n) begin
      if (bus.mem_we) begin
        chk("byte_ready_in_write", 32'(bus.byte_ready), 32'd0);
        if (wq.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          w = wq.pop_front();
          chk("write_addr", 32'(bus.mem_addr), 32'(w.addr));
          chk("write_data", 32'(bus.mem_wdata), 32'(w.data));
        end
      end
      if (bus.load_done) begin
        chk("restart_with_done", 32'(bus.cpu_restart), 32'd1);
        if (dq.size() == 0) begin
          fail_now("unexpected_load_done");
        end else begin
          d = dq.pop_front();
          chk("done_words_loaded", 32'(bus.words_loaded), 32'(d.words));
          chk("done_load_err", 32'(bus.load_err), 32'(d.err));
        end
      end
    end
  end

  task automatic start_load(input logic [AW:0] cnt);
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_count = cnt;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    int tmo;
    tmo = 0;
    acc_cyc = -1;
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    while (!bus.byte_ready && tmo < 200) begin
      tmo++;
      @(negedge clk);
    end
    if (!bus.byte_ready) fail_now("byte_accept_timeout");
    else acc_cyc = cyc;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap, output int first_cyc);
    int c;
    first_cyc = -1;
    for (int i = 0; i < tx.size(); i++) begin
      send_byte(tx[i], gap, c);
      if (i == 0) first_cyc = c;
    end
    tx.delete();
  endtask

  task automatic wait_done(output int dcyc);
    int tmo;
    tmo = 0;
    dcyc = -1;
    @(negedge clk);
    while (!bus.load_done && tmo < 100) begin
      tmo++;
      @(negedge clk);
    end
    if (!bus.load_done) fail_now("load_done_timeout");
    else dcyc = cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int cd;
    logic [7:0] k8;
    logic [7:0] fa [3];

    bus.load_start = 1'b0;
    bus.load_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.fetch_addr = 8'h5A;

    // Reset state
    #1;
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_load_err", 32'(bus.load_err), 32'd0);
    chk("rst_words_loaded", 32'(bus.words_loaded), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h5A);
    #21 rst_n = 1'b1;

    // Idle passthrough
    fa[0] = 8'h00; fa[1] = 8'h05; fa[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.fetch_addr = fa[i];
      #1;
      chk("idle_mem_addr", 32'(bus.mem_addr), 32'(fa[i]));
      chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
      chk("idle_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    end

    // Two-word load, continuous stream
    wq.push_back('{addr: 8'd0, data: 20'hABCDE});
    wq.push_back('{addr: 8'd1, data: 20'h12345});
    dq.push_back('{words: 9'd2, err: 1'b0});
    tx = '{8'h0A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45};
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_count = 9'd2;
    #1 chk("stall_before_accept", 32'(bus.cpu_stall), 32'd0);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    chk("stall_after_accept", 32'(bus.cpu_stall), 32'd1);
    send_stream(0, c0);
    wait_done(cd);
    chk("two_word_cycles", 32'(cd - c0 + 1), 32'd9);
    chk("stall_released", 32'(bus.cpu_stall), 32'd0);

    // Gapped stream, same words
    wq.push_back('{addr: 8'd0, data: 20'hABCDE});
    wq.push_back('{addr: 8'd1, data: 20'h12345});
    dq.push_back('{words: 9'd2, err: 1'b0});
    tx = '{8'h0A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45};
    start_load(9'd2);
    send_stream(2, c0);
    wait_done(cd);

    // Overflowing upper bits
    wq.push_back('{addr: 8'd0, data: 20'h10000});
    dq.push_back('{words: 9'd1, err: 1'b1});
    tx = '{8'hF1, 8'h00, 8'h00};
    start_load(9'd1);
    send_stream(0, c0);
    wait_done(cd);

    // Zero-length load goes straight to DONE
    dq.push_back('{words: 9'd0, err: 1'b0});
    start_load(9'd0);
    chk("zero_len_done", 32'(bus.load_done), 32'd1);
    chk("zero_len_no_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    chk("zero_len_idle", 32'(bus.cpu_stall), 32'd0);

    // Ignored load_start during RECV
    wq.push_back('{addr: 8'd0, data: 20'h13579});
    wq.push_back('{addr: 8'd1, data: 20'h2468A});
    dq.push_back('{words: 9'd2, err: 1'b0});
    start_load(9'd2);
    send_byte(8'h01, 0, c0);
    bus.load_start = 1'b1;
    bus.load_count = 9'd5;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    chk("ignored_start_ready", 32'(bus.byte_ready), 32'd1);
    tx = '{8'h35, 8'h79, 8'h02, 8'h46, 8'h8A};
    send_stream(0, c0);
    wait_done(cd);

    // Clamped oversize load
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      wq.push_back('{addr: k8, data: 20'({k8, ~k8})});
      tx.push_back(8'h00);
      tx.push_back(k8);
      tx.push_back(~k8);
    end
    dq.push_back('{words: 9'd256, err: 1'b1});
    start_load(9'd300);
    chk("clamp_err_early", 32'(bus.load_err), 32'd1);
    send_stream(0, c0);
    wait_done(cd);
    chk("clamp_mem_last", 32'(mem_model[255]), 32'h0FF00);

    // Reset mid-load
    bus.fetch_addr = 8'h33;
    wq.push_back('{addr: 8'd0, data: 20'h555AA});
    tx = '{8'h05, 8'h55, 8'hAA, 8'h07};
    start_load(9'd3);
    send_stream(0, c0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("midrst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_words_loaded", 32'(bus.words_loaded), 32'd0);
    chk("midrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'h33);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_word0_kept", 32'(mem_model[0]), 32'h555AA);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.cpu_stall), 32'd0);

    // Scoreboard drained
    chk("writes_outstanding", 32'(wq.size()), 32'd0);
    chk("dones_outstanding", 32'(dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
